// File: rtl/twiddle_mult5_pkg.sv
// Shared FFT constants for the radix-5 twiddle stage:
// default widths, rounding constant and the twiddle quantiser.
package twiddle_mult5_pkg;

    localparam int  WIDTH_DEF    = 14;
    localparam int  TW_WIDTH_DEF = 12;
    localparam int  M_DEF        = 12;
    localparam int  LEGS         = 5;
    localparam real PI           = 3.14159265358979323846;

    function automatic int round_const(input int tw_width);
        return 1 << (tw_width - 3);
    endfunction

    // W = cos(a) - j*sin(a), a = 2*pi*e/n, with 1.0 = 2^(tw_width-2)
    function automatic int tw_quant(input int e, input int n,
                                    input int tw_width, input bit is_im);
        real ang;
        real v;
        ang = 2.0 * PI * real'(e) / real'(n);
        v   = is_im ? -$sin(ang) : $cos(ang);
        v   = v * real'(1 << (tw_width - 2));
        if (v >= 0.0)
            return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

endpackage

// File: rtl/twiddle_mult5_rom.sv
// Twiddle table: N quantised cos / -sin pairs addressed by exponent e.
// Pure lookup with a registered output; no control logic here.
module twiddle_rom
    import twiddle_mult5_pkg::*;
#(
    parameter int TW_WIDTH = TW_WIDTH_DEF,
    parameter int N        = LEGS * M_DEF,
    parameter int AW       = $clog2(N)
) (
    input  logic                       clk,
    input  logic [AW-1:0]              i_addr,
    output logic signed [TW_WIDTH-1:0] o_w_re,
    output logic signed [TW_WIDTH-1:0] o_w_im
);

    logic signed [TW_WIDTH-1:0] w_cos [N];
    logic signed [TW_WIDTH-1:0] w_sin [N];
    logic signed [TW_WIDTH-1:0] r_re;
    logic signed [TW_WIDTH-1:0] r_im;

    for (genvar g = 0; g < N; g++) begin : g_tab
        localparam logic signed [TW_WIDTH-1:0] C =
            TW_WIDTH'(tw_quant(g, N, TW_WIDTH, 1'b0));
        localparam logic signed [TW_WIDTH-1:0] S =
            TW_WIDTH'(tw_quant(g, N, TW_WIDTH, 1'b1));
        assign w_cos[g] = C;
        assign w_sin[g] = S;
    end

    always_ff @(posedge clk) begin
        r_re <= w_cos[i_addr];
        r_im <= w_sin[i_addr];
    end

    assign o_w_re = r_re;
    assign o_w_im = r_im;

endmodule

// File: rtl/twiddle_mult5.sv
// Radix-5 SDF inter-stage twiddle multiplier, 3-cycle latency.
// Exponent e = (n*k) mod N is tracked incrementally per frame.
module twiddle_mult5
    import twiddle_mult5_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TW_WIDTH = TW_WIDTH_DEF,
    parameter int M        = M_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    input  logic                    on,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im
);

    localparam int N  = LEGS * M;
    localparam int AW = $clog2(N);
    localparam int NW = (M > 1) ? $clog2(M) : 1;
    localparam int PW = WIDTH + TW_WIDTH + 1;
    localparam int SH = TW_WIDTH - 2;
    localparam logic signed [PW-1:0] RND  = PW'(round_const(TW_WIDTH));
    localparam logic signed [PW-1:0] VMAX = PW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [PW-1:0] VMIN = -VMAX - PW'(1);

    logic [AW-1:0] r_i;
    logic [AW-1:0] r_e;
    logic [NW-1:0] r_n;
    logic [2:0]    r_k;

    always_ff @(posedge clk) begin
        if (rst || !on) begin
            r_i <= '0;
            r_e <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (di_en) begin
            if (r_n == NW'(M - 1)) begin
                r_n <= '0;
                r_e <= '0;
                if (r_i == AW'(N - 1)) begin
                    r_i <= '0;
                    r_k <= '0;
                end else begin
                    r_i <= r_i + AW'(1);
                    r_k <= r_k + 3'd1;
                end
            end else begin
                r_n <= r_n + NW'(1);
                r_e <= r_e + AW'(r_k);
                r_i <= r_i + AW'(1);
            end
        end
    end

    logic signed [TW_WIDTH-1:0] w_wre;
    logic signed [TW_WIDTH-1:0] w_wim;

    twiddle_rom #(
        .TW_WIDTH(TW_WIDTH),
        .N       (N),
        .AW      (AW)
    ) u_rom (
        .clk   (clk),
        .i_addr(r_e),
        .o_w_re(w_wre),
        .o_w_im(w_wim)
    );

    logic                    r_s1_en, r_s2_en;
    logic                    r_s1_on, r_s2_on;
    logic signed [WIDTH-1:0] r_s1_re, r_s1_im;
    logic signed [WIDTH-1:0] r_s2_re, r_s2_im;
    logic signed [PW-2:0]    r_ac, r_bd, r_ad, r_bc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_en <= 1'b0;
            r_s2_en <= 1'b0;
        end else begin
            r_s1_en <= di_en;
            r_s2_en <= r_s1_en;
        end
    end

    always_ff @(posedge clk) begin
        r_s1_on <= on;
        r_s1_re <= di_re;
        r_s1_im <= di_im;
        r_s2_on <= r_s1_on;
        r_s2_re <= r_s1_re;
        r_s2_im <= r_s1_im;
        r_ac    <= (PW-1)'(r_s1_re) * (PW-1)'(w_wre);
        r_bd    <= (PW-1)'(r_s1_im) * (PW-1)'(w_wim);
        r_ad    <= (PW-1)'(r_s1_re) * (PW-1)'(w_wim);
        r_bc    <= (PW-1)'(r_s1_im) * (PW-1)'(w_wre);
    end

    logic signed [PW-1:0] w_sre, w_sim;
    logic signed [PW-1:0] w_rre, w_rim;

    assign w_sre = PW'(r_ac) - PW'(r_bd);
    assign w_sim = PW'(r_ad) + PW'(r_bc);
    assign w_rre = (w_sre + RND) >>> SH;
    assign w_rim = (w_sim + RND) >>> SH;

    function automatic logic signed [WIDTH-1:0] f_sat(
        input logic signed [PW-1:0] v
    );
        if (v > VMAX)
            return VMAX[WIDTH-1:0];
        if (v < VMIN)
            return VMIN[WIDTH-1:0];
        return v[WIDTH-1:0];
    endfunction

    // Bypass path carries the raw sample: no rounding or clipping
    always_ff @(posedge clk) begin
        if (rst) begin
            do_en <= 1'b0;
            do_re <= '0;
            do_im <= '0;
        end else begin
            do_en <= r_s2_en;
            do_re <= r_s2_on ? f_sat(w_rre) : r_s2_re;
            do_im <= r_s2_on ? f_sat(w_rim) : r_s2_im;
        end
    end

endmodule

// File: tb/tb_twiddle_mult5.sv
// Directed bench for twiddle_mult5 (M=12, WIDTH=14, TW_WIDTH=12).
// Expected outputs are hand-computed and tracked through a 3-deep queue.
module tb_twiddle_mult5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               di_en;
    logic               on;
    logic signed [13:0] di_re;
    logic signed [13:0] di_im;
    logic               do_en;
    logic signed [13:0] do_re;
    logic signed [13:0] do_im;

    twiddle_mult5 #(
        .WIDTH   (14),
        .TW_WIDTH(12),
        .M       (12)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .di_en(di_en),
        .di_re(di_re),
        .di_im(di_im),
        .on   (on),
        .do_en(do_en),
        .do_re(do_re),
        .do_im(do_im)
    );

    typedef struct {
        int i;
        int re;
        int im;
        int xre;
        int xim;
    } vec_t;

    typedef struct {
        logic en;
        int   re;
        int   im;
    } ent_t;

    vec_t tab[32];
    int   n_tab;
    ent_t pend[$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input int i, input int re, input int im,
                       input int xre, input int xim);
        tab[n_tab] = '{i: i, re: re, im: im, xre: xre, xim: xim};
        n_tab++;
    endtask

    function automatic int find(input int i);
        for (int t = 0; t < n_tab; t++)
            if (tab[t].i == i)
                return t;
        return -1;
    endfunction

    task automatic check_out(input ent_t e);
        chk("do_en", int'(do_en), int'(e.en));
        if (e.en) begin
            chk("do_re", int'(do_re), e.re);
            chk("do_im", int'(do_im), e.im);
        end
    endtask

    task automatic drive(input logic en, input logic o,
                         input int re, input int im,
                         input int xre, input int xim);
        ent_t e;
        di_en = en;
        on    = o;
        di_re = 14'(re);
        di_im = 14'(im);
        e = '{en: en, re: xre, im: xim};
        pend.push_back(e);
        @(posedge clk);
        #1;
        if (pend.size() == 3) begin
            e = pend.pop_front();
            check_out(e);
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++)
            drive(1'b0, 1'b1, 0, 0, 0, 0);
    endtask

    // rst asserted with di_en=1 and on=1 to exercise its priority
    task automatic do_reset();
        ent_t z;
        rst   = 1'b1;
        di_en = 1'b1;
        on    = 1'b1;
        di_re = 14'sd777;
        di_im = -14'sd777;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        di_en = 1'b0;
        chk("rst_do_en", int'(do_en), 0);
        chk("rst_do_re", int'(do_re), 0);
        chk("rst_do_im", int'(do_im), 0);
        pend.delete();
        z = '{en: 1'b0, re: 0, im: 0};
        pend.push_back(z);
        pend.push_back(z);
    endtask

    task automatic run_frame(input int nsamp, input bit gaps);
        int t;
        for (int i = 0; i < nsamp; i++) begin
            if (gaps && (i % 3 == 1))
                drive(1'b0, 1'b1, 99, -99, 0, 0);
            if (gaps && (i % 7 == 5))
                drive(1'b0, 1'b1, -55, 55, 0, 0);
            t = find(i);
            if (t >= 0)
                drive(1'b1, 1'b1, tab[t].re, tab[t].im,
                      tab[t].xre, tab[t].xim);
            else
                drive(1'b1, 1'b1, 0, 0, 0, 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        n_tab    = 0;
        rst      = 1'b1;
        di_en    = 1'b0;
        on       = 1'b0;
        di_re    = '0;
        di_im    = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 12; i++)
            add(i, 1000, -500, 1000, -500);
        add(12, 300, -200, 300, -200);
        add(24, 300, -200, 300, -200);
        add(36, 300, -200, 300, -200);
        add(48, 300, -200, 300, -200);
        add(15, 1000, 0, 951, -309);
        add(27, 1000, 0, 809, -588);
        add(29, 1000, 0, 500, -866);
        add(41, -8192, -8192, -8192, 8191);
        add(52, 0, 1000, 994, -104);

        run_frame(60, 1'b0);
        idle(3);
        run_frame(60, 1'b1);
        idle(3);

        run_frame(30, 1'b0);
        do_reset();
        run_frame(20, 1'b0);

        drive(1'b1, 1'b0, 1234, -77, 1234, -77);
        drive(1'b0, 1'b0, 5, 5, 0, 0);
        drive(1'b1, 1'b0, -8192, 8191, -8192, 8191);
        drive(1'b1, 1'b1, 1000, 0, 1000, 0);
        drive(1'b1, 1'b1, 0, 1000, 0, 1000);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
